// File: rtl/scalar_pkg.sv
// Shared types and constants for the scalar issue stage.
// Opcodes, S-register address width and datapath type.
package scalar_pkg;
  localparam int S_ADDR_W = 3;
  localparam logic [6:0] OP_SADD = 7'o104;
  localparam logic [6:0] OP_SSUB = 7'o105;
  localparam logic [6:0] OP_SPOP = 7'o106;
  localparam logic [6:0] OP_SLZC = 7'o107;
  typedef logic [63:0] sreg_t;
endpackage

// File: rtl/s_register_file.sv
// S register file: two operand reads, debug read, and two
// write ports where FU writeback beats the external load.
module s_register_file
  import scalar_pkg::*;
#(
  parameter int NREG = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [S_ADDR_W-1:0] rd_j_addr,
  input  logic [S_ADDR_W-1:0] rd_k_addr,
  input  logic [S_ADDR_W-1:0] rd_d_addr,
  output logic [63:0]         rd_j_data,
  output logic [63:0]         rd_k_data,
  output logic [63:0]         rd_d_data,
  input  logic                wb_en,
  input  logic [S_ADDR_W-1:0] wb_addr,
  input  logic [63:0]         wb_data,
  input  logic                ext_en,
  input  logic [S_ADDR_W-1:0] ext_addr,
  input  logic [63:0]         ext_data
);

  sreg_t s [NREG];

  assign rd_j_data = s[rd_j_addr];
  assign rd_k_data = s[rd_k_addr];
  assign rd_d_data = s[rd_d_addr];

  // Register array update; writeback wins on an address clash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NREG; n++) s[n] <= '0;
    end else begin
      if (ext_en && !(wb_en && wb_addr == ext_addr))
        s[ext_addr] <= ext_data;
      if (wb_en)
        s[wb_addr] <= wb_data;
    end
  end

endmodule

// File: rtl/scalar_issue_ctl.sv
// Scalar integer operand fetch / issue stage with per-register
// reservations and fixed-latency writeback from the FU.
module scalar_issue_ctl
  import scalar_pkg::*;
#(
  parameter int FU_LAT = 2,
  parameter int NREG   = 8
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_Valid,
  output logic        o_Ready,
  input  logic [6:0]  i_Op,
  input  logic [2:0]  i_I,
  input  logic [2:0]  i_J,
  input  logic [2:0]  i_K,
  output logic [6:0]  o_Instr,
  output logic [63:0] o_Sj,
  output logic [63:0] o_Sk,
  input  logic [63:0] i_Si,
  input  logic        i_Wr_en,
  input  logic [2:0]  i_Wr_addr,
  input  logic [63:0] i_Wr_data,
  output logic        o_Wr_err,
  output logic        o_Ill,
  input  logic [2:0]  i_Rd_addr,
  output logic [63:0] o_Rd_data,
  output logic        o_Busy
);

  localparam int P = FU_LAT + 1;
  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  logic [NREG-1:0]     res;
  logic [P-1:0]        pv;
  logic [S_ADDR_W-1:0] pa [P];
  sreg_t               rd_j, rd_k;
  sreg_t               sk_val;
  logic                legal, src_k;
  logic                accept, issue;
  logic                wb_en, wr_ok;
  logic [S_ADDR_W-1:0] wb_addr;
  logic                is_ss, is_pop, is_lzc;

  assign is_ss  = (i_Op == OP_SADD) || (i_Op == OP_SSUB);
  assign is_pop = (i_Op == OP_SPOP);
  assign is_lzc = (i_Op == OP_SLZC);

  // Opcode decode: legality, k-source use and Sk operand.
  always_comb begin
    legal  = 1'b1;
    src_k  = 1'b0;
    sk_val = '0;
    unique case (1'b1)
      is_ss: begin
        src_k  = 1'b1;
        sk_val = rd_k;
      end
      is_pop: sk_val = {63'b0, i_K[0]};
      is_lzc: sk_val = '0;
      default: legal = 1'b0;
    endcase
  end

  assign o_Ready = !legal ||
                   !(res[i_J] || (src_k && res[i_K]) || res[i_I]);
  assign accept  = i_Valid && o_Ready;
  assign issue   = accept && legal;
  assign wb_en   = pv[P-1];
  assign wb_addr = pa[P-1];
  assign wr_ok   = i_Wr_en && !res[i_Wr_addr] &&
                   !(wb_en && wb_addr == i_Wr_addr);
  assign o_Busy  = |res;

  s_register_file #(.NREG(NREG)) u_rf (
    .clk       (clk),
    .rst_n     (i_rst_n),
    .rd_j_addr (i_J),
    .rd_k_addr (i_K),
    .rd_d_addr (i_Rd_addr),
    .rd_j_data (rd_j),
    .rd_k_data (rd_k),
    .rd_d_data (o_Rd_data),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (i_Si),
    .ext_en    (wr_ok),
    .ext_addr  (i_Wr_addr),
    .ext_data  (i_Wr_data)
  );

  // Reservations: set on issue, cleared on writeback.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)
      res <= '0;
    else
      res <= (res & ~(wb_en ? (ONE << wb_addr) : '0)) |
             (issue ? (ONE << i_I) : '0);
  end

  // Destination shift pipe tracking results in flight.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pv <= '0;
      for (int n = 0; n < P; n++) pa[n] <= '0;
    end else begin
      pv[0] <= issue;
      pa[0] <= i_I;
      for (int n = 1; n < P; n++) begin
        pv[n] <= pv[n-1];
        pa[n] <= pa[n-1];
      end
    end
  end

  // FU drive registers and status pulses.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_Instr  <= '0;
      o_Sj     <= '0;
      o_Sk     <= '0;
      o_Wr_err <= 1'b0;
      o_Ill    <= 1'b0;
    end else begin
      o_Wr_err <= i_Wr_en && !wr_ok;
      o_Ill    <= accept && !legal;
      if (issue) begin
        o_Instr <= i_Op;
        o_Sj    <= rd_j;
        o_Sk    <= sk_val;
      end else begin
        o_Instr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_scalar_issue_ctl.sv
// Directed self-checking bench for scalar_issue_ctl with a
// small two-stage FU model feeding i_Si.
module tb_scalar_issue_ctl;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_Valid;
  logic        o_Ready;
  logic [6:0]  i_Op;
  logic [2:0]  i_I, i_J, i_K;
  logic [6:0]  o_Instr;
  logic [63:0] o_Sj, o_Sk;
  logic [63:0] i_Si;
  logic        i_Wr_en;
  logic [2:0]  i_Wr_addr;
  logic [63:0] i_Wr_data;
  logic        o_Wr_err, o_Ill;
  logic [2:0]  i_Rd_addr;
  logic [63:0] o_Rd_data;
  logic        o_Busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] fu0 = '0;
  logic [63:0] fu1 = '0;

  always #5 clk = ~clk;

  scalar_issue_ctl #(.FU_LAT(2), .NREG(8)) dut (
    .clk       (clk),
    .i_rst_n   (i_rst_n),
    .i_Valid   (i_Valid),
    .o_Ready   (o_Ready),
    .i_Op      (i_Op),
    .i_I       (i_I),
    .i_J       (i_J),
    .i_K       (i_K),
    .o_Instr   (o_Instr),
    .o_Sj      (o_Sj),
    .o_Sk      (o_Sk),
    .i_Si      (i_Si),
    .i_Wr_en   (i_Wr_en),
    .i_Wr_addr (i_Wr_addr),
    .i_Wr_data (i_Wr_data),
    .o_Wr_err  (o_Wr_err),
    .o_Ill     (o_Ill),
    .i_Rd_addr (i_Rd_addr),
    .o_Rd_data (o_Rd_data),
    .o_Busy    (o_Busy)
  );

  function automatic logic [63:0] fu_f(
    logic [6:0] op, logic [63:0] a, logic [63:0] b);
    logic [63:0] n;
    case (op)
      7'o104: return a + b;
      7'o105: return a - b;
      7'o106: return b[0] ? {63'b0, ^a} : 64'($countones(a));
      7'o107: begin
        n = 64;
        for (int i = 0; i < 64; i++) if (a[i]) n = 64'(63 - i);
        return n;
      end
      default: return '0;
    endcase
  endfunction

  // FU model: samples inputs, result valid two edges later.
  always @(posedge clk) begin
    fu0 <= fu_f(o_Instr, o_Sj, o_Sk);
    fu1 <= fu0;
  end
  assign i_Si = fu1;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(string tag, logic [2:0] a, logic [63:0] exp);
    i_Rd_addr = a;
    #1;
    chk(tag, o_Rd_data, exp);
  endtask

  task automatic ext_wr(logic [2:0] a, logic [63:0] d);
    i_Wr_en   = 1'b1;
    i_Wr_addr = a;
    i_Wr_data = d;
    tick();
    i_Wr_en   = 1'b0;
  endtask

  task automatic put(logic [6:0] op, logic [2:0] i, logic [2:0] j,
                     logic [2:0] k);
    i_Valid = 1'b1;
    i_Op    = op;
    i_I     = i;
    i_J     = j;
    i_K     = k;
  endtask

  initial begin
    i_rst_n   = 1'b0;
    i_Valid   = 1'b0;
    i_Op      = '0;
    i_I       = '0;
    i_J       = '0;
    i_K       = '0;
    i_Wr_en   = 1'b0;
    i_Wr_addr = '0;
    i_Wr_data = '0;
    i_Rd_addr = '0;
    tick();
    tick();
    chk("rst_instr", 64'(o_Instr), 64'h0);
    chk("rst_sj", o_Sj, 64'h0);
    chk("rst_sk", o_Sk, 64'h0);
    chk("rst_busy", 64'(o_Busy), 64'h0);
    chk("rst_wrerr", 64'(o_Wr_err), 64'h0);
    chk("rst_ill", 64'(o_Ill), 64'h0);
    chk_reg("rst_s0", 3'd0, 64'h0);
    i_rst_n = 1'b1;
    tick();

    // Add, then RAW-dependent subtract
    ext_wr(3'd1, 64'd5);
    ext_wr(3'd2, 64'd3);
    ext_wr(3'd7, 64'hDEAD);
    chk_reg("ld_s1", 3'd1, 64'd5);
    put(7'o104, 3'd3, 3'd1, 3'd2);
    chk("add_ready", 64'(o_Ready), 64'd1);
    tick();
    chk("add_instr", 64'(o_Instr), 64'o104);
    chk("add_sj", o_Sj, 64'd5);
    chk("add_sk", o_Sk, 64'd3);
    chk("add_busy0", 64'(o_Busy), 64'd1);
    put(7'o105, 3'd4, 3'd3, 3'd1);
    #1;
    chk("raw_stall0", 64'(o_Ready), 64'd0);
    tick();
    chk("idle_instr", 64'(o_Instr), 64'h0);
    chk("idle_sj_hold", o_Sj, 64'd5);
    chk("raw_stall1", 64'(o_Ready), 64'd0);
    chk("add_busy1", 64'(o_Busy), 64'd1);
    tick();
    chk("raw_stall2", 64'(o_Ready), 64'd0);
    chk("add_busy2", 64'(o_Busy), 64'd1);
    tick();
    chk_reg("add_s3", 3'd3, 64'd8);
    chk("raw_ready", 64'(o_Ready), 64'd1);
    tick();
    i_Valid = 1'b0;
    chk("sub_instr", 64'(o_Instr), 64'o105);
    chk("sub_sj", o_Sj, 64'd8);
    chk("sub_sk", o_Sk, 64'd5);
    tick();
    tick();
    tick();
    chk_reg("sub_s4", 3'd4, 64'd3);

    // Pop/parity/lzc issued back to back
    ext_wr(3'd5, 64'h00FF);
    ext_wr(3'd1, 64'd1);
    put(7'o106, 3'd6, 3'd5, 3'd0);
    chk("pop_ready", 64'(o_Ready), 64'd1);
    tick();
    chk("pop_instr", 64'(o_Instr), 64'o106);
    chk("pop_sj", o_Sj, 64'hFF);
    chk("pop_sk", o_Sk, 64'd0);
    put(7'o106, 3'd7, 3'd5, 3'd1);
    #1;
    chk("par_ready", 64'(o_Ready), 64'd1);
    tick();
    chk("par_sk", o_Sk, 64'd1);
    put(7'o107, 3'd2, 3'd1, 3'd5);
    #1;
    chk("lzc_ready", 64'(o_Ready), 64'd1);
    tick();
    i_Valid = 1'b0;
    chk("lzc_instr", 64'(o_Instr), 64'o107);
    chk("lzc_sk", o_Sk, 64'd0);
    tick();
    tick();
    tick();
    chk_reg("pop_s6", 3'd6, 64'd8);
    chk_reg("par_s7", 3'd7, 64'd0);
    chk_reg("lzc_s2", 3'd2, 64'd63);

    // Write conflict; S1=1, S2=63 so S3 gets 64
    put(7'o104, 3'd3, 3'd1, 3'd2);
    tick();
    i_Valid   = 1'b0;
    i_Wr_en   = 1'b1;
    i_Wr_addr = 3'd3;
    i_Wr_data = 64'hBAD;
    tick();
    i_Wr_en = 1'b0;
    chk("wr_err_pulse", 64'(o_Wr_err), 64'd1);
    tick();
    chk("wr_err_clear", 64'(o_Wr_err), 64'd0);
    i_Wr_en   = 1'b1;
    i_Wr_addr = 3'd3;
    i_Wr_data = 64'hBAD;
    tick();
    chk("wb_clash_err", 64'(o_Wr_err), 64'd1);
    chk_reg("wb_clash_s3", 3'd3, 64'd64);
    i_Wr_addr = 3'd5;
    i_Wr_data = 64'h77;
    tick();
    i_Wr_en = 1'b0;
    chk("wr_ok_err", 64'(o_Wr_err), 64'd0);
    chk_reg("wr_ok_s5", 3'd5, 64'h77);

    // Illegal opcode
    put(7'o110, 3'd0, 3'd0, 3'd0);
    #1;
    chk("ill_ready", 64'(o_Ready), 64'd1);
    tick();
    i_Valid = 1'b0;
    chk("ill_pulse", 64'(o_Ill), 64'd1);
    chk("ill_busy", 64'(o_Busy), 64'd0);
    chk("ill_instr", 64'(o_Instr), 64'h0);
    tick();
    chk("ill_clear", 64'(o_Ill), 64'd0);

    // Reset mid-flight
    put(7'o104, 3'd4, 3'd1, 3'd2);
    tick();
    i_Valid = 1'b0;
    chk("mid_busy", 64'(o_Busy), 64'd1);
    tick();
    i_rst_n = 1'b0;
    #1;
    chk("mrst_busy", 64'(o_Busy), 64'd0);
    chk("mrst_instr", 64'(o_Instr), 64'h0);
    chk_reg("mrst_s1", 3'd1, 64'd0);
    tick();
    i_rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk_reg("mrst_s4", 3'd4, 64'd0);
    chk("mrst_busy2", 64'(o_Busy), 64'd0);
    chk("mrst_instr2", 64'(o_Instr), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
